// File: rtl/bcd_counter_scan.sv
// Two-digit BCD up/down counter with synchronous load and a time-multiplexed
// digit output (W/X/Y/Z plus sel) for a shared segment decoder.
module bcd_counter_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] ld_tens,
  input  logic [3:0] ld_ones,
  output logic       W,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       sel,
  output logic       co,
  output logic       err
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [3:0]        tens_reg, tens_next;
  logic [3:0]        ones_reg, ones_next;
  logic              co_reg, co_next;
  logic              err_reg, err_next;
  logic [SCAN_W-1:0] scan_reg, scan_next;
  logic              sel_reg, sel_next;
  logic              load_ok;
  logic [3:0]        digit_sel;

  assign load_ok = (ld_tens <= 4'd9) && (ld_ones <= 4'd9);

  // Count update: each digit is computed directly to its BCD result, so no
  // A..F value is ever written to a digit register.
  always_comb begin
    tens_next = tens_reg;
    ones_next = ones_reg;
    co_next   = 1'b0;
    err_next  = 1'b0;
    if (load) begin
      if (load_ok) begin
        tens_next = ld_tens;
        ones_next = ld_ones;
      end else begin
        err_next = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (ones_reg == 4'd9) begin
          ones_next = 4'd0;
          if (tens_reg == 4'd9) begin
            tens_next = 4'd0;
            co_next   = 1'b1;
          end else begin
            tens_next = tens_reg + 4'd1;
          end
        end else begin
          ones_next = ones_reg + 4'd1;
        end
      end else begin
        if (ones_reg == 4'd0) begin
          ones_next = 4'd9;
          if (tens_reg == 4'd0) begin
            tens_next = 4'd9;
            co_next   = 1'b1;
          end else begin
            tens_next = tens_reg - 4'd1;
          end
        end else begin
          ones_next = ones_reg - 4'd1;
        end
      end
    end
  end

  // Free-running digit scan; sel flips on the edge that wraps the divider.
  always_comb begin
    scan_next = scan_reg + SCAN_W'(1);
    sel_next  = sel_reg;
    if (scan_reg == SCAN_LAST) begin
      scan_next = '0;
      sel_next  = ~sel_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_reg <= 4'd0;
      ones_reg <= 4'd0;
      co_reg   <= 1'b0;
      err_reg  <= 1'b0;
      scan_reg <= '0;
      sel_reg  <= 1'b0;
    end else begin
      tens_reg <= tens_next;
      ones_reg <= ones_next;
      co_reg   <= co_next;
      err_reg  <= err_next;
      scan_reg <= scan_next;
      sel_reg  <= sel_next;
    end
  end

  // Digit mux driven purely from registers: no input reaches W/X/Y/Z.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit_mux
      assign digit_sel[gi] = sel_reg ? tens_reg[gi] : ones_reg[gi];
    end
  endgenerate

  assign W   = digit_sel[3];
  assign X   = digit_sel[2];
  assign Y   = digit_sel[1];
  assign Z   = digit_sel[0];
  assign sel = sel_reg;
  assign co  = co_reg;
  assign err = err_reg;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Bench for bcd_counter_scan: directed scenarios then random traffic, all
// checked against a decimal (0..99) reference model of the count and scan.
module tb_bcd_counter_scan;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] ld_tens = 4'd0;
  logic [3:0] ld_ones = 4'd0;
  logic       W, X, Y, Z, sel, co, err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: count as a plain integer, scan as edges since reset.
  int cnt = 0;
  int ticks = 0;
  bit m_co = 1'b0;
  bit m_err = 1'b0;

  bcd_counter_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .ld_tens(ld_tens), .ld_ones(ld_ones),
    .W(W), .X(X), .Y(Y), .Z(Z), .sel(sel), .co(co), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    cnt = 0; ticks = 0; m_co = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit u, input bit l,
                            input int lt, input int lo);
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_co = 1'b0;
    m_err = 1'b0;
    if (l) begin
      if (lt <= 9 && lo <= 9) cnt = lt * 10 + lo;
      else m_err = 1'b1;
    end else if (e) begin
      if (u) begin
        cnt = cnt + 1;
        if (cnt == 100) begin cnt = 0; m_co = 1'b1; end
      end else begin
        cnt = cnt - 1;
        if (cnt < 0) begin cnt = 99; m_co = 1'b1; end
      end
    end
    ticks++;
  endtask

  task automatic check_all(input string tag);
    logic [3:0] obs_d, exp_d;
    logic       exp_sel;
    exp_sel = 1'((ticks / SCAN_DIV) % 2);
    exp_d   = exp_sel ? 4'(cnt / 10) : 4'(cnt % 10);
    obs_d   = {W, X, Y, Z};
    vectors++;
    assert (obs_d === exp_d) else begin
      miscompares++;
      $error("FAIL %s wxyz: observed %b expected %b (count %0d)", tag, obs_d, exp_d, cnt);
    end
    vectors++;
    assert (sel === exp_sel) else begin
      miscompares++;
      $error("FAIL %s sel: observed %b expected %b", tag, sel, exp_sel);
    end
    vectors++;
    assert (co === m_co) else begin
      miscompares++;
      $error("FAIL %s co: observed %b expected %b (count %0d)", tag, co, m_co, cnt);
    end
    vectors++;
    assert (err === m_err) else begin
      miscompares++;
      $error("FAIL %s err: observed %b expected %b", tag, err, m_err);
    end
  endtask

  // Drive inputs, take one clock edge, check 1 ns later.
  task automatic step(input bit e, input bit u, input bit l,
                      input logic [3:0] lt, input logic [3:0] lo, input string tag);
    en = e; up = u; load = l; ld_tens = lt; ld_ones = lo;
    @(posedge clk);
    model_edge(e, u, l, int'(lt), int'(lo));
    #1 check_all(tag);
  endtask

  initial begin
    // Power-on reset, asserted between edges, held across edges with en high.
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("por");
    step(1, 1, 0, 4'd0, 4'd0, "rst_hold_en");
    step(0, 0, 1, 4'd5, 4'd5, "rst_hold_load");
    rst_n = 1'b1;

    // Full up sweep: 00..99 and back to 00 with a single co.
    for (int i = 0; i < 100; i++) step(1, 1, 0, 4'd0, 4'd0, "up_sweep");
    step(0, 1, 0, 4'd0, 4'd0, "hold_after_sweep");

    // Load 00 then step down: 99 with co, then 98 without.
    step(0, 0, 1, 4'd0, 4'd0, "load_00");
    step(1, 0, 0, 4'd0, 4'd0, "down_wrap");
    step(1, 0, 0, 4'd0, 4'd0, "down_98");

    // Rejected loads leave the count alone; en ignored during any load.
    step(0, 0, 1, 4'd3, 4'd7, "load_37");
    step(1, 1, 1, 4'd4, 4'd12, "bad_ones");
    step(1, 1, 1, 4'd4, 4'd2, "load_42");
    step(1, 0, 1, 4'd11, 4'd3, "bad_tens");
    step(0, 0, 0, 4'd0, 4'd0, "err_clears");

    // Back-to-back wraps and load at 99 must not pulse co.
    step(0, 0, 1, 4'd9, 4'd9, "load_99");
    step(1, 1, 0, 4'd0, 4'd0, "wrap_up");
    step(1, 0, 0, 4'd0, 4'd0, "wrap_down");
    step(1, 1, 0, 4'd0, 4'd0, "wrap_up2");
    step(0, 0, 1, 4'd9, 4'd9, "load_99b");
    step(0, 1, 1, 4'd0, 4'd0, "load_00_no_co");

    // Held at 59: scan alternates 1001 (ones) / 0101 (tens).
    step(0, 0, 1, 4'd5, 4'd9, "load_59");
    for (int i = 0; i < 4 * SCAN_DIV; i++) step(0, 0, 0, 4'd0, 4'd0, "scan_59");

    // Reset mid-cycle while counting up from 98, and while err is pulsing.
    step(0, 0, 1, 4'd9, 4'd8, "load_98");
    step(1, 1, 0, 4'd0, 4'd0, "up_99");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_mid_count");
    step(1, 1, 0, 4'd0, 4'd0, "rst_mid_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 4'd0, 4'd0, "restart_up");
    step(0, 0, 1, 4'd12, 4'd0, "bad_before_rst");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_mid_err");
    rst_n = 1'b1;
    step(0, 0, 0, 4'd0, 4'd0, "no_err_after_rst");

    // Random traffic against the decimal model.
    for (int i = 0; i < 10000; i++) begin
      bit          e, u, l;
      logic [3:0]  lt, lo;
      e  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      l  = ($urandom_range(0, 15) == 0);
      lt = 4'($urandom_range(0, 15));
      lo = 4'($urandom_range(0, 15));
      step(e, u, l, lt, lo, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_counter_scan.md
BCD_COUNTER_SCAN -- requirements
Module: bcd_counter_scan

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 4: clock cycles each digit is presented on W/X/Y/Z before the scan advances (legal range 2..256).
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide port en  input  1  count enable; one step per clock while high.
REQ-005 SHALL provide port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 SHALL provide port load  input  1  synchronous load strobe.
REQ-007 SHALL provide port ld_tens  input  4  BCD tens digit to load.
REQ-008 SHALL provide port ld_ones  input  4  BCD ones digit to load.
REQ-009 SHALL provide ports W, X, Y, Z  output  1 each  scanned BCD digit; W = bit 3 (MSB), Z = bit 0; these feed the segment decoder directly.
REQ-010 SHALL provide port sel  output  1  digit currently on W/X/Y/Z; 0 = ones, 1 = tens.
REQ-011 SHALL provide port co  output  1  one-cycle wrap pulse (carry on 99->00, borrow on 00->99).
REQ-012 SHALL provide port err  output  1  one-cycle pulse flagging a rejected load.

Function
REQ-013 SHALL hold the count as two 4-bit BCD registers, tens and ones, each always in 0..9.
REQ-014 SHALL, when load=1 and both ld_tens and ld_ones are <=9, set tens/ones to the load values on the next edge; co=0 that cycle.
REQ-015 SHALL, when load=1 and either load digit is >9, leave the count unchanged and drive err=1 for exactly the following cycle.
REQ-016 SHALL give load priority over en; en is ignored in any cycle with load=1 (valid or not).
REQ-017 SHALL, when en=1, load=0, up=1: ones 0..8 -> ones+1; ones 9 -> ones 0 and tens+1; count 99 -> 00.
REQ-018 SHALL, when en=1, load=0, up=0: ones 1..9 -> ones-1; ones 0 -> ones 9 and tens-1; count 00 -> 99.
REQ-019 SHALL hold the count when en=0 and load=0.
REQ-020 SHALL register co so it is high in exactly the cycle in which the wrapped value (00 on up, 99 on down) first appears on the count registers; back-to-back wraps give co high every wrapping cycle.
REQ-021 SHALL never produce an intermediate non-BCD value (A-F) on any digit register.
REQ-022 SHALL run a free-running scan counter 0..SCAN_DIV-1, independent of en/load; when it reaches SCAN_DIV-1 it returns to 0 and sel toggles on the same edge.
REQ-023 SHALL drive {W,X,Y,Z} = ones when sel=0 and tens when sel=1, decoded only from registered state (no input-to-output combinational path).
REQ-024 SHALL show a count change on W/X/Y/Z in the same cycle the register updates if that digit is currently selected.

Reset
REQ-025 SHALL, on rst_n low, immediately (asynchronously) clear tens, ones, scan counter, sel, co and err to 0, giving W=X=Y=Z=0.
REQ-026 SHALL hold all state at reset values while rst_n is low, regardless of en/load, and resume on the first rising clk edge after rst_n deasserts.
REQ-027 SHALL discard any in-progress load, count step or co/err pulse when reset asserts mid-operation; no pulse appears after release.

Verification
REQ-028 SHALL cover: reset, en=1, up=1 for 100 cycles -> count 00..99 then 00; co high only in the cycle count returns to 00.
REQ-029 SHALL cover: load 00 (valid), en=1, up=0 one cycle -> count 99, co=1 that cycle; next step -> 98, co=0.
REQ-030 SHALL cover: load=1, ld_tens=4, ld_ones=12 with count 37 -> count stays 37, err=1 one cycle; then load 4/2 with en=1 -> count 42, co=0, err=0.
REQ-031 SHALL cover: SCAN_DIV=4, count held at 59 -> sel 0 for 4 cycles with WXYZ=1001, then sel 1 for 4 cycles with WXYZ=0101, repeating.
REQ-032 SHALL cover: count 98 counting up, rst_n pulsed low mid-cycle -> outputs 0 before next edge, no co after release, counting restarts at 00.
REQ-033 SHALL cover: en toggled randomly with up random for 10k cycles against a decimal reference model -> count, co and WXYZ always match; no digit >9.
